uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/edge_bit_counter.sv | 42 ++++
 rtl/uart_rx_ctrl.sv | 123 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller.
//   state_t         : receiver FSM state encoding
//   PRESCALE_8/16   : the two supported oversampling ratios
//   legal_prescale  : maps any prescale value onto a supported ratio
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;

    // Unsupported ratios run as x16 so a bad setting can never stretch a
    // frame beyond 16 clocks per bit.
    function automatic logic [4:0] legal_prescale(input logic [4:0] p);
        return (p == 5'(PRESCALE_8)) ? p : 5'(PRESCALE_16);
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and bit counter for the UART receiver.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : count while high; both counters are held at zero when low
//   clear      : holds bit_cnt at zero (edge counting continues)
//   prescale   : edges per bit (already latched by the controller)
//   edge_cnt   : edge index inside the current bit, 0..prescale-1
//   bit_cnt    : number of completed bits since clear was released
//   bit_done   : high on the last edge of a bit (the bit boundary)
module edge_bit_counter #(
    parameter int BIT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [4:0]       prescale,
    output logic [4:0]       edge_cnt,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             bit_done
);

    assign bit_done = enable && (edge_cnt == prescale - 5'd1);

    // NOTE: sequential state is updated with <= so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            edge_cnt <= bit_done ? 5'd0 : edge_cnt + 5'd1;
            if (clear)
                bit_cnt <= '0;
            else if (bit_done)
                bit_cnt <= bit_cnt + BIT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, deserializer and parity/stop checks.
//   clk, rst      : oversampling clock, asynchronous active-high reset
//   RX_IN         : serial line (idle high), used only for start detection
//   prescale      : oversampling ratio (8 or 16), latched at frame start
//   PAR_EN        : parity bit present, latched at frame start
//   PAR_TYP       : 0 even / 1 odd parity, latched at frame start
//   sampled_bit   : majority-voted bit value from the sampling stage
//   data_samp_en  : enables the sampling stage while a frame is active
//   edge_cnt      : oversampling edge index within the current bit
//   P_DATA        : received word (LSB first on the line)
//   data_valid    : one-cycle pulse after a frame with no errors
//   par_err       : one-cycle pulse after a frame with a parity mismatch
//   stp_err       : one-cycle pulse after a frame whose stop bit was 0
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [4:0]            prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  data_samp_en,
    output logic [4:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    state_t                state, state_next;
    logic [4:0]            presc_q;
    logic                  par_en_q, par_typ_q, par_mis_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  bit_done, last_bit;
    logic                  cnt_clear, start_frame, shift_en, par_chk, stop_chk;

    edge_bit_counter #(.BIT_W(BIT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .enable   (data_samp_en),
        .clear    (cnt_clear),
        .prescale (presc_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done)
    );

    assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign P_DATA   = shift_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first, so no path leaves state_next
        // unassigned and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:   if (!RX_IN)   state_next = START;
            START:  if (bit_done) state_next = sampled_bit ? IDLE : DATA;
            DATA:   if (bit_done && last_bit)
                        state_next = par_en_q ? PARITY : STOP;
            PARITY: if (bit_done) state_next = STOP;
            STOP:   if (bit_done) state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        data_samp_en = (state != IDLE);
        // bit_cnt only counts inside DATA, so it indexes the payload bits.
        cnt_clear    = (state != DATA);
        start_frame  = (state == IDLE) && !RX_IN;
        shift_en     = (state == DATA)   && bit_done;
        par_chk      = (state == PARITY) && bit_done;
        stop_chk     = (state == STOP)   && bit_done;
    end

    // Frame configuration, deserializer, checks and result pulses
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register here, including the data shift register,
        // has an explicit reset so no partial frame survives a reset.
        if (rst) begin
            presc_q    <= 5'(PRESCALE_8);
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_mis_q  <= 1'b0;
            shift_q    <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            if (start_frame) begin
                presc_q   <= legal_prescale(prescale);
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_mis_q <= 1'b0;
            end
            if (shift_en)
                shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
            if (par_chk)
                par_mis_q <= (sampled_bit != ((^shift_q) ^ par_typ_q));
            data_valid <= stop_chk && sampled_bit && !par_mis_q;
            par_err    <= stop_chk && par_mis_q;
            stp_err    <= stop_chk && !sampled_bit;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a table of complete frames plus
// hand-written sequences for glitch rejection, back-to-back frames,
// mid-frame reset and an unsupported prescale value.
module tb_uart_rx_ctrl;

    logic       clk, rst, RX_IN, PAR_EN, PAR_TYP, sampled_bit;
    logic [4:0] prescale;
    logic       data_samp_en, data_valid, par_err, stp_err;
    logic [4:0] edge_cnt;
    logic [7:0] P_DATA;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .prescale     (prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .sampled_bit  (sampled_bit),
        .data_samp_en (data_samp_en),
        .edge_cnt     (edge_cnt),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: counts pulses and records when they happened.
    int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0, samp_cycles = 0;
    int         start_cyc = 0, pulse_cyc = 0;
    int         dv_cyc[64];
    logic [7:0] dv_data[64];
    logic       overlap = 1'b0;
    logic       samp_prev = 1'b0;

    always @(negedge clk) begin
        if (data_samp_en && !samp_prev) start_cyc = cyc;
        samp_prev = data_samp_en;
        if (data_samp_en) samp_cycles++;
        if (data_valid) begin
            dv_cyc[dv_cnt % 64]  = cyc;
            dv_data[dv_cnt % 64] = P_DATA;
            dv_cnt++;
            pulse_cyc = cyc;
        end
        if (par_err) begin pe_cnt++; pulse_cyc = cyc; end
        if (stp_err) begin se_cnt++; pulse_cyc = cyc; end
        if (data_valid && (par_err || stp_err)) overlap = 1'b1;
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int p);
        RX_IN       = v;
        sampled_bit = v;
        repeat (p) @(negedge clk);
    endtask

    // Falling edge seen by IDLE; afterwards the config inputs are scrambled
    // to prove they were latched at frame start.
    task automatic detect(input int presc, input logic pen, input logic ptyp);
        prescale    = 5'(presc);
        PAR_EN      = pen;
        PAR_TYP     = ptyp;
        RX_IN       = 1'b0;
        sampled_bit = 1'b0;
        @(negedge clk);
        prescale = (presc == 8) ? 5'd16 : 5'd8;
        PAR_EN   = ~pen;
        PAR_TYP  = ~ptyp;
    endtask

    task automatic send_frame(input int presc, input logic pen, input logic ptyp,
                              input logic [7:0] data, input logic pbit, input logic sbit);
        detect(presc, pen, ptyp);
        drive_bit(1'b0, presc);
        for (int b = 0; b < 8; b++) drive_bit(data[b], presc);
        if (pen) drive_bit(pbit, presc);
        drive_bit(sbit, presc);
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
    endtask

    typedef struct {
        int         presc;
        logic       par_en;
        logic       par_typ;
        logic [7:0] data;
        logic       par_bit;
        logic       stop_bit;
        logic       exp_dv;
        logic       exp_pe;
        logic       exp_se;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int dv0, pe0, se0, s0, n;

        //           presc par typ data   pbit stop  dv  pe  se
        vecs[0] = '{8,  0, 0, 8'hA5, 0, 1, 1, 0, 0};
        vecs[1] = '{16, 1, 0, 8'h3C, 0, 1, 1, 0, 0};  // even, 4 ones
        vecs[2] = '{16, 1, 0, 8'h3C, 1, 1, 0, 1, 0};  // wrong parity
        vecs[3] = '{8,  0, 0, 8'h55, 0, 0, 0, 0, 1};  // stop bit low
        vecs[4] = '{16, 1, 1, 8'h3C, 1, 1, 1, 0, 0};  // odd, 4 ones
        vecs[5] = '{8,  1, 0, 8'h07, 1, 1, 1, 0, 0};  // even, 3 ones
        vecs[6] = '{8,  1, 0, 8'h07, 1, 0, 0, 0, 1};  // good parity, bad stop
        vecs[7] = '{8,  1, 1, 8'hFF, 0, 0, 0, 1, 1};  // both errors

        rst = 1'b1; RX_IN = 1'b1; sampled_bit = 1'b1;
        prescale = 5'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        check("reset samp_en",    int'(data_samp_en), 0);
        check("reset edge_cnt",   int'(edge_cnt),     0);
        check("reset P_DATA",     int'(P_DATA),       0);
        check("reset data_valid", int'(data_valid),   0);
        check("reset par_err",    int'(par_err),      0);
        check("reset stp_err",    int'(stp_err),      0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table of complete frames
        for (int i = 0; i < 8; i++) begin
            dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
            send_frame(vecs[i].presc, vecs[i].par_en, vecs[i].par_typ,
                       vecs[i].data, vecs[i].par_bit, vecs[i].stop_bit);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d data_valid count", i), dv_cnt - dv0, int'(vecs[i].exp_dv));
            check($sformatf("v%0d par_err count", i),    pe_cnt - pe0, int'(vecs[i].exp_pe));
            check($sformatf("v%0d stp_err count", i),    se_cnt - se0, int'(vecs[i].exp_se));
            check($sformatf("v%0d P_DATA", i),           int'(P_DATA), int'(vecs[i].data));
            // Pulse appears one bit-time per frame bit after START entry.
            check($sformatf("v%0d latency", i), pulse_cyc - start_cyc,
                  vecs[i].presc * (10 + int'(vecs[i].par_en)));
            check($sformatf("v%0d back to idle", i), int'(data_samp_en), 0);
        end

        // Glitch: line low for 2 clk, sampler still reports high
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt; s0 = samp_cycles;
        prescale = 5'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        RX_IN = 1'b0; sampled_bit = 1'b1;
        repeat (2) @(negedge clk);
        RX_IN = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch active cycles", samp_cycles - s0, 8);
        check("glitch data_valid",    dv_cnt - dv0, 0);
        check("glitch par_err",       pe_cnt - pe0, 0);
        check("glitch stp_err",       se_cnt - se0, 0);
        check("glitch idle edge_cnt", int'(edge_cnt), 0);

        // Back-to-back frames: second falling edge in the IDLE cycle that
        // carries the first data_valid, so pulses are 160 clk of frame plus
        // that one detection cycle apart.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(16, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1);
        send_frame(16, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("b2b data_valid count", dv_cnt - dv0, 2);
        check("b2b first P_DATA",     int'(dv_data[dv0 % 64]), 8'h01);
        check("b2b second P_DATA",    int'(dv_data[(dv0 + 1) % 64]), 8'hFE);
        check("b2b pulse spacing",    dv_cyc[(dv0 + 1) % 64] - dv_cyc[dv0 % 64], 161);
        check("b2b errors",           (pe_cnt - pe0) + (se_cnt - se0), 0);

        // P_DATA held through the next start bit, then reset during bit 4
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        detect(8, 1'b0, 1'b0);
        drive_bit(1'b0, 8);
        check("P_DATA held after start bit", int'(P_DATA), 8'hFE);
        for (int b = 0; b < 4; b++) drive_bit(b == 0, 8);
        drive_bit(1'b0, 2);
        #2 rst = 1'b1;
        RX_IN = 1'b1; sampled_bit = 1'b1;
        #1;
        check("midframe rst samp_en",    int'(data_samp_en), 0);
        check("midframe rst edge_cnt",   int'(edge_cnt),     0);
        check("midframe rst P_DATA",     int'(P_DATA),       0);
        check("midframe rst data_valid", int'(data_valid),   0);
        check("midframe rst par_err",    int'(par_err),      0);
        check("midframe rst stp_err",    int'(stp_err),      0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("after rst still idle", int'(data_samp_en), 0);
        check("no partial frame pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("post rst data_valid count", dv_cnt - dv0, 1);
        check("post rst P_DATA",           int'(P_DATA), 8'h81);
        check("post rst errors",           (pe_cnt - pe0) + (se_cnt - se0), 0);

        // Unsupported prescale must not trap the FSM
        prescale = 5'd0;
        RX_IN = 1'b0; sampled_bit = 1'b1;
        @(negedge clk);
        RX_IN = 1'b1;
        n = 0;
        while (data_samp_en && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("illegal prescale returns to idle", int'(!data_samp_en && n < 352), 1);

        check("data_valid exclusive of errors", int'(overlap), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
